ahb2apb_bridge: RTL

AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

---
 rtl/ahb_apb_pkg.sv | 36 +++
 rtl/ahb_slave_if.sv | 62 ++++++
 rtl/ahb2apb_bridge.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-to-APB bridge: transfer types, peripheral regions
// and FSM states.
package ahb_apb_pkg;

   typedef enum logic [1:0] {
      HtransIdle   = 2'b00,
      HtransBusy   = 2'b01,
      HtransNonseq = 2'b10,
      HtransSeq    = 2'b11
   } htrans_e;

   localparam logic [31:0] Region0Base = 32'h8000_0000;
   localparam logic [31:0] Region1Base = 32'h8400_0000;
   localparam logic [31:0] Region2Base = 32'h8800_0000;
   localparam logic [31:0] RegionSize  = 32'h0400_0000;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StRenable,
      StWwait,
      StWrite,
      StWenable
   } state_e;

   // One-hot peripheral select; all-zero for addresses outside the three regions.
   function automatic logic [2:0] region_sel(input logic [31:0] addr);
      logic [2:0] sel;
      sel = 3'b000;
      if (addr >= Region0Base && addr < Region0Base + RegionSize) sel = 3'b001;
      if (addr >= Region1Base && addr < Region1Base + RegionSize) sel = 3'b010;
      if (addr >= Region2Base && addr < Region2Base + RegionSize) sel = 3'b100;
      return sel;
   endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-side front end: transfer qualification, region decode, and the stage-1
// address/direction/select registers plus the write-data register.
module ahb_slave_if
   import ahb_apb_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        hwrite_i,
   input  logic        hreadyin_i,
   input  logic [1:0]  htrans_i,
   input  logic [31:0] haddr_i,
   input  logic [31:0] hwdata_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [2:0]  sel_o,
   output logic [31:0] addr_o,
   output logic        write_o,
   output logic [2:0]  sel_q_o,
   output logic [31:0] hwdata_o
);

   logic [31:0] addr_q;
   logic        write_q;
   logic [2:0]  sel_q;
   logic        wr_acc_q;
   logic [31:0] hwdata_q;
   logic        accept;

   always_comb begin
      sel_o   = region_sel(haddr_i);
      valid_o = hreadyin_i && (sel_o != 3'b000) &&
                (htrans_i == HtransNonseq || htrans_i == HtransSeq);
   end

   // While the bridge stalls the master (ready low) the bus inputs are ignored.
   assign accept = valid_o && ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q   <= 32'h0;
         write_q  <= 1'b0;
         sel_q    <= 3'b000;
         wr_acc_q <= 1'b0;
         hwdata_q <= 32'h0;
      end else begin
         if (accept) begin
            addr_q  <= haddr_i;
            write_q <= hwrite_i;
            sel_q   <= sel_o;
         end
         wr_acc_q <= accept && hwrite_i;
         // Write data arrives one cycle after its address phase.
         if (wr_acc_q) hwdata_q <= hwdata_i;
      end
   end

   assign addr_o   = addr_q;
   assign write_o  = write_q;
   assign sel_q_o  = sel_q;
   assign hwdata_o = hwdata_q;

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-to-APB bridge: transfer FSM driving registered APB outputs and the
// AHB ready signal.
module ahb2apb_bridge
   import ahb_apb_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        Hwrite,
   input  logic        Hreadyin,
   input  logic [1:0]  Htrans,
   input  logic [31:0] Haddr,
   input  logic [31:0] Hwdata,
   input  logic [31:0] Prdata,
   output logic        Hreadyout,
   output logic [1:0]  Hresp,
   output logic [31:0] Hrdata,
   output logic [2:0]  Pselx,
   output logic        Penable,
   output logic        Pwrite,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata
);

   state_e      state_q, state_d;
   logic [2:0]  pselx_q, pselx_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [31:0] paddr_q, paddr_d;
   logic        hreadyout_q, hreadyout_d;

   logic        valid;
   logic [2:0]  sel;
   logic [31:0] addr_s1;
   logic        write_s1;
   logic [2:0]  sel_s1;
   logic [31:0] hwdata_s1;

   ahb_slave_if u_slave_if (
      .clk_i      (HCLK),
      .rst_ni     (HRESETn),
      .hwrite_i   (Hwrite),
      .hreadyin_i (Hreadyin),
      .htrans_i   (Htrans),
      .haddr_i    (Haddr),
      .hwdata_i   (Hwdata),
      .ready_i    (hreadyout_q),
      .valid_o    (valid),
      .sel_o      (sel),
      .addr_o     (addr_s1),
      .write_o    (write_s1),
      .sel_q_o    (sel_s1),
      .hwdata_o   (hwdata_s1)
   );

   // Outputs are computed for the state being entered, so they are valid in it.
   always_comb begin
      state_d     = state_q;
      pselx_d     = pselx_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      hreadyout_d = hreadyout_q;
      unique case (state_q)
         StIdle, StRenable, StWenable: begin
            state_d     = StIdle;
            pselx_d     = 3'b000;
            penable_d   = 1'b0;
            hreadyout_d = 1'b1;
            if (valid && !Hwrite) begin
               state_d     = StRead;
               pselx_d     = sel;
               paddr_d     = Haddr;
               pwrite_d    = 1'b0;
               hreadyout_d = 1'b0;
            end else if (valid) begin
               state_d     = StWwait;
               hreadyout_d = 1'b0;
            end
         end
         StRead: begin
            state_d     = StRenable;
            penable_d   = 1'b1;
            hreadyout_d = 1'b1;
         end
         StWwait: begin
            state_d     = StWrite;
            pselx_d     = sel_s1;
            paddr_d     = addr_s1;
            pwrite_d    = write_s1;
            hreadyout_d = 1'b0;
         end
         StWrite: begin
            state_d     = StWenable;
            penable_d   = 1'b1;
            hreadyout_d = 1'b1;
         end
         default: begin
            state_d     = StIdle;
            pselx_d     = 3'b000;
            penable_d   = 1'b0;
            hreadyout_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= StIdle;
         pselx_q     <= 3'b000;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= 32'h0;
         hreadyout_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         pselx_q     <= pselx_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         hreadyout_q <= hreadyout_d;
      end
   end

   assign Pselx     = pselx_q;
   assign Penable   = penable_q;
   assign Pwrite    = pwrite_q;
   assign Paddr     = paddr_q;
   assign Pwdata    = hwdata_s1;
   assign Hreadyout = hreadyout_q;
   assign Hresp     = 2'b00;
   assign Hrdata    = Prdata;

endmodule
